// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : GPR pending-write scoreboard for the ID stage. Tracks
//                long-latency destination registers, raises RAW/WAW/full
//                stalls, and keeps sticky spurious-completion and
//                stall-watchdog flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_read_en_1,
  input  logic        id_read_en_2,
  input  logic [4:0]  id_read_addr_1,
  input  logic [4:0]  id_read_addr_2,
  input  logic        id_write_en,
  input  logic [4:0]  id_write_addr,
  input  logic        id_long,
  input  logic        ext_stall,
  input  logic        done_en,
  input  logic [4:0]  done_addr,
  input  logic        flush,
  output logic        stall_id,
  output logic [1:0]  stall_reason,
  output logic [31:0] pending,
  output logic [3:0]  out_count,
  output logic        err_spurious,
  output logic        stall_timeout
);

  localparam logic [1:0] c_reason_none = 2'b00;
  localparam logic [1:0] c_reason_raw  = 2'b01;
  localparam logic [1:0] c_reason_waw  = 2'b10;
  localparam logic [1:0] c_reason_full = 2'b11;
  localparam logic [3:0] c_max_out     = MAX_OUT[3:0];
  localparam logic [7:0] c_timeout     = TIMEOUT[7:0];

  logic [31:0] pending_q, pending_d;
  logic [3:0]  out_count_q, out_count_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;
  logic        err_spurious_q, err_spurious_d;
  logic        stall_timeout_q, stall_timeout_d;

  logic [31:0] w_clr_mask;
  logic [31:0] w_set_mask;
  logic [31:0] w_eff;
  logic        w_clr_any;
  logic        w_set_any;
  logic        w_raw;
  logic        w_waw;
  logic        w_full;
  logic        w_issue;

  // Completion mask: only a pending register can be retired (bit 0 is never pending).
  always_comb begin
    w_clr_mask = '0;
    if (done_en && pending_q[done_addr]) begin
      w_clr_mask[done_addr] = 1'b1;
    end
  end

  assign w_eff     = pending_q & ~w_clr_mask;
  assign w_clr_any = |w_clr_mask;

  // Hazard detection against the scoreboard with same-cycle completions already retired.
  always_comb begin
    w_raw  = id_valid &&
             ((id_read_en_1 && (id_read_addr_1 != 5'd0) && w_eff[id_read_addr_1]) ||
              (id_read_en_2 && (id_read_addr_2 != 5'd0) && w_eff[id_read_addr_2]));
    w_waw  = id_valid && id_write_en && (id_write_addr != 5'd0) && w_eff[id_write_addr];
    // $0 is never tracked, so a long write to it can never need a slot.
    w_full = id_valid && id_long && id_write_en && (id_write_addr != 5'd0) &&
             (out_count_q == c_max_out) && !w_clr_any;
  end

  // Stall decision and prioritised reason code.
  always_comb begin
    stall_id     = w_raw || w_waw || w_full;
    stall_reason = c_reason_none;
    if (w_raw) begin
      stall_reason = c_reason_raw;
    end else if (w_waw) begin
      stall_reason = c_reason_waw;
    end else if (w_full) begin
      stall_reason = c_reason_full;
    end
  end

  assign w_issue = id_valid && !stall_id && !ext_stall && !flush;

  // New pending bit for an issued long-latency write to a real GPR.
  always_comb begin
    w_set_mask = '0;
    if (w_issue && id_long && id_write_en && (id_write_addr != 5'd0)) begin
      w_set_mask[id_write_addr] = 1'b1;
    end
  end

  assign w_set_any = |w_set_mask;

  // Next-state: scoreboard, occupancy, watchdog counter and sticky flags.
  always_comb begin
    if (flush) begin
      pending_d   = '0;
      out_count_d = '0;
    end else begin
      // Clear applied before set so a same-address retire+issue stays pending.
      pending_d   = (pending_q & ~w_clr_mask) | w_set_mask;
      out_count_d = out_count_q + {3'b000, w_set_any} - {3'b000, w_clr_any};
    end

    if (!stall_id) begin
      stall_cnt_d = 8'd0;
    end else if (stall_cnt_q == 8'hFF) begin
      stall_cnt_d = 8'hFF;
    end else begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end

    err_spurious_d  = err_spurious_q || (done_en && !pending_q[done_addr]);
    stall_timeout_d = stall_timeout_q || (stall_id && (stall_cnt_d == c_timeout));
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q       <= '0;
      out_count_q     <= '0;
      stall_cnt_q     <= '0;
      err_spurious_q  <= 1'b0;
      stall_timeout_q <= 1'b0;
    end else begin
      pending_q       <= pending_d;
      out_count_q     <= out_count_d;
      stall_cnt_q     <= stall_cnt_d;
      err_spurious_q  <= err_spurious_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign pending       = pending_q;
  assign out_count     = out_count_q;
  assign err_spurious  = err_spurious_q;
  assign stall_timeout = stall_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_scoreboard
//  Description : Self-checking bench for reg_scoreboard. A driver issues
//                directed and random cycles, predicts each cycle's outputs
//                from a register-set model and queues them; a monitor pops
//                and compares every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

  localparam int MAX_OUT = 4;
  localparam int TIMEOUT = 10;

  logic        clk;
  logic        rst;
  logic        id_valid, id_read_en_1, id_read_en_2, id_write_en, id_long;
  logic [4:0]  id_read_addr_1, id_read_addr_2, id_write_addr, done_addr;
  logic        ext_stall, done_en, flush;
  logic        stall_id, err_spurious, stall_timeout;
  logic [1:0]  stall_reason;
  logic [31:0] pending;
  logic [3:0]  out_count;

  reg_scoreboard #(.MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_read_en_1(id_read_en_1), .id_read_en_2(id_read_en_2),
    .id_read_addr_1(id_read_addr_1), .id_read_addr_2(id_read_addr_2),
    .id_write_en(id_write_en), .id_write_addr(id_write_addr),
    .id_long(id_long), .ext_stall(ext_stall),
    .done_en(done_en), .done_addr(done_addr), .flush(flush),
    .stall_id(stall_id), .stall_reason(stall_reason),
    .pending(pending), .out_count(out_count),
    .err_spurious(err_spurious), .stall_timeout(stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit       rst_n;
    bit       valid;
    bit       re1;
    bit       re2;
    bit [4:0] ra1;
    bit [4:0] ra2;
    bit       we;
    bit [4:0] wa;
    bit       lng;
    bit       ext;
    bit       den;
    bit [4:0] da;
    bit       flush;
  } stim_t;

  typedef struct packed {
    bit        stall;
    bit [1:0]  reason;
    bit [31:0] pend;
    bit [3:0]  cnt;
    bit        err;
    bit        to;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Reference model: the set of registers awaiting a long-latency result.
  bit mp[32];
  int mstall;
  bit merr, mto;

  function automatic int mcount();
    int n = 0;
    for (int i = 0; i < 32; i++) n += mp[i] ? 1 : 0;
    return n;
  endfunction

  function automatic bit busy(input bit [4:0] a, input bit clr_v, input bit [4:0] da);
    return (a != 5'd0) && mp[a] && !(clr_v && (a == da));
  endfunction

  function automatic stim_t idle();
    stim_t s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t lw(input bit [4:0] a);
    stim_t s = idle();
    s.valid = 1'b1; s.we = 1'b1; s.lng = 1'b1; s.wa = a;
    return s;
  endfunction

  function automatic stim_t rd(input bit [4:0] a);
    stim_t s = idle();
    s.valid = 1'b1; s.re1 = 1'b1; s.ra1 = a;
    return s;
  endfunction

  function automatic stim_t with_done(input stim_t s0, input bit [4:0] a);
    stim_t s = s0;
    s.den = 1'b1; s.da = a;
    return s;
  endfunction

  // Apply one cycle of stimulus, predict outputs, advance the model.
  task automatic step(input stim_t s);
    exp_t e;
    bit   clr_v, raw, waw, full, stall, iss;
    @(negedge clk);
    rst = s.rst_n;
    id_valid = s.valid; id_read_en_1 = s.re1; id_read_en_2 = s.re2;
    id_read_addr_1 = s.ra1; id_read_addr_2 = s.ra2;
    id_write_en = s.we; id_write_addr = s.wa; id_long = s.lng;
    ext_stall = s.ext; done_en = s.den; done_addr = s.da; flush = s.flush;

    if (!s.rst_n) begin
      for (int i = 0; i < 32; i++) mp[i] = 1'b0;
      mstall = 0; merr = 1'b0; mto = 1'b0;
    end

    clr_v = s.den && mp[s.da];
    raw   = s.valid && ((s.re1 && busy(s.ra1, clr_v, s.da)) ||
                        (s.re2 && busy(s.ra2, clr_v, s.da)));
    waw   = s.valid && s.we && busy(s.wa, clr_v, s.da);
    full  = s.valid && s.lng && s.we && (s.wa != 5'd0) &&
            (mcount() == MAX_OUT) && !clr_v;
    stall = raw || waw || full;

    e.stall  = stall;
    e.reason = raw ? 2'd1 : waw ? 2'd2 : full ? 2'd3 : 2'd0;
    for (int i = 0; i < 32; i++) e.pend[i] = mp[i];
    e.cnt    = 4'(mcount());
    e.err    = merr;
    e.to     = mto;
    exp_q.push_back(e);

    if (s.rst_n) begin
      iss  = s.valid && !stall && !s.ext && !s.flush;
      merr = merr || (s.den && !mp[s.da]);
      mstall = stall ? ((mstall < 255) ? mstall + 1 : 255) : 0;
      mto  = mto || (mstall >= TIMEOUT);
      if (s.flush) begin
        for (int i = 0; i < 32; i++) mp[i] = 1'b0;
      end else begin
        if (clr_v) mp[s.da] = 1'b0;
        if (iss && s.lng && s.we && (s.wa != 5'd0)) mp[s.wa] = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: compare every presented cycle against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall_id",      {31'd0, stall_id},      {31'd0, e.stall});
        check("stall_reason",  {30'd0, stall_reason},  {30'd0, e.reason});
        check("pending",       pending,                e.pend);
        check("out_count",     {28'd0, out_count},     {28'd0, e.cnt});
        check("err_spurious",  {31'd0, err_spurious},  {31'd0, e.err});
        check("stall_timeout", {31'd0, stall_timeout}, {31'd0, e.to});
      end
    end
  end

  // Driver: directed scenarios, then randomized traffic.
  initial begin
    stim_t s;
    int    plist[$];
    rst = 1'b0;
    id_valid = 0; id_read_en_1 = 0; id_read_en_2 = 0; id_write_en = 0; id_long = 0;
    id_read_addr_1 = 0; id_read_addr_2 = 0; id_write_addr = 0; done_addr = 0;
    ext_stall = 0; done_en = 0; flush = 0;
    for (int i = 0; i < 32; i++) mp[i] = 1'b0;
    mstall = 0; merr = 1'b0; mto = 1'b0;

    s = idle(); s.rst_n = 1'b0;
    step(s); step(s);
    step(idle());

    // Load-use stall resolved by a same-cycle completion.
    step(lw(5'd8));
    step(rd(5'd8));
    step(with_done(rd(5'd8), 5'd8));
    step(idle());

    // Occupancy limit, relieved by a completion in the same cycle.
    for (int a = 1; a <= 4; a++) step(lw(5'(a)));
    step(lw(5'd5));
    step(with_done(lw(5'd5), 5'd2));
    step(idle());
    step(with_done(idle(), 5'd1));
    step(with_done(idle(), 5'd3));
    step(with_done(idle(), 5'd4));
    step(with_done(idle(), 5'd5));

    // WAW against a pending register, and untracked writes to $0.
    step(lw(5'd9));
    s = lw(5'd9); s.lng = 1'b0;
    step(s);
    step(lw(5'd0));
    step(with_done(idle(), 5'd9));

    // Retire and re-issue of the same register in one cycle.
    step(lw(5'd6));
    step(with_done(lw(5'd6), 5'd6));
    step(idle());
    step(with_done(idle(), 5'd6));

    // Flush of in-flight writes, then a completion that no longer matches.
    step(lw(5'd1)); step(lw(5'd2)); step(lw(5'd7));
    s = idle(); s.flush = 1'b1;
    step(s);
    step(with_done(idle(), 5'd7));
    step(idle());

    // Watchdog on a held RAW stall, then reset mid-stall.
    s = idle(); s.rst_n = 1'b0;
    step(s);
    step(lw(5'd3));
    for (int i = 0; i < 12; i++) step(rd(5'd3));
    s = rd(5'd3); s.rst_n = 1'b0;
    step(s);
    s = idle(); s.rst_n = 1'b0;
    step(s);
    step(rd(5'd3));

    // Randomized traffic with a small register window to force hazards.
    for (int n = 0; n < 2000; n++) begin
      s = idle();
      s.valid = ($urandom_range(0, 3) != 0);
      s.re1   = $urandom_range(0, 1) == 1;
      s.re2   = $urandom_range(0, 1) == 1;
      s.ra1   = 5'($urandom_range(0, 7));
      s.ra2   = 5'($urandom_range(0, 7));
      s.we    = ($urandom_range(0, 3) != 0);
      s.wa    = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      s.lng   = $urandom_range(0, 1) == 1;
      s.ext   = ($urandom_range(0, 7) == 0);
      s.flush = ($urandom_range(0, 63) == 0);
      s.rst_n = ($urandom_range(0, 299) != 0);
      s.den   = ($urandom_range(0, 2) == 0);
      plist.delete();
      for (int i = 0; i < 32; i++) if (mp[i]) plist.push_back(i);
      if (plist.size() > 0 && $urandom_range(0, 15) != 0)
        s.da = 5'(plist[$urandom_range(0, plist.size() - 1)]);
      else
        s.da = 5'($urandom_range(0, 31));
      step(s);
    end
    step(idle());

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #5;
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
